decode_regfile: RTL and testbench
=================================

Name: decode_regfile

Overview:
- Decode stage of the single-cycle RV32I core; sits directly downstream of Fetch and consumes its `instruction` and `current_procount` outputs.
- Splits the instruction into fields, generates the sign-extended immediate and the control bundle, and reads two operands from an internal 32x32 register file.
- The register file is written at the clock edge from the writeback port.
- A sticky illegal-instruction trap register captures the PC of the first unsupported opcode.

Parameters:
- DATA_WIDTH, 32, register/immediate/PC width; only 32 is supported.
- ALU_OP_W, 4, width of `alu_op`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- instruction  in  32  instruction word from Fetch.
- current_procount  in  32  PC of `instruction`, from Fetch.
- wb_en  in  1  register write enable.
- wb_rd  in  5  write destination index.
- wb_data  in  32  write data.
- rs1_data  out  32  register-file value of rs1.
- rs2_data  out  32  register-file value of rs2.
- imm  out  32  sign-extended immediate.
- rd  out  5  instruction[11:7].
- funct3  out  3  instruction[14:12].
- pc_out  out  32  `current_procount` passed through.
- reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jalr, pc_to_alu  out  1 each  control bundle.
- alu_op  out  ALU_OP_W  ALU operation select.
- illegal  out  1  current instruction is unsupported (combinational).
- trap_valid  out  1  sticky; an illegal opcode has been decoded since reset.
- trap_pc  out  32  PC of the first illegal instruction.

Behaviour:
- Register file, 32 entries x 32 bits:
  - Reads are combinational; index 0 always reads 0.
  - Write: at the rising edge when reset_n=1, wb_en=1 and wb_rd!=0, regs[wb_rd] <= wb_data. Writes to x0 are discarded.
  - No write-through: a read issued in the same cycle as a write to that register returns the old value. The new value is visible from the next cycle. This is required so the single-cycle path has no combinational loop.
- Reset (edge with reset_n=0):
  - All 31 registers go to 0; trap_valid <= 0; trap_pc <= 0.
  - While reset_n=0, all control outputs are forced to 0 (NOP): reg_write, mem_*, branch, jump, jalr, alu_src, pc_to_alu, illegal, and alu_op=0.
  - rs1_data/rs2_data show the current register contents (0 after the first reset edge). imm, rd, funct3 and pc_out stay field-decoded.
  - A reset asserted mid-program clears everything on that edge; a wb_en in the same cycle is ignored.
- Immediates:
  - I: sext(ins[31:20]).
  - S: sext({ins[31:25], ins[11:7]}).
  - B: sext({ins[31], ins[7], ins[30:25], ins[11:8], 0}).
  - U: {ins[31:12], 12'b0}.
  - J: sext({ins[31], ins[19:12], ins[20], ins[30:21], 0}).
  - R-type and illegal: imm = 0.
- Opcode decode (reset_n=1):
  - 0110011 OP: reg_write.
    - alu_op from {funct7[5], funct3}: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - 0010011 OP-IMM: reg_write, alu_src, I-imm.
    - alu_op as for OP, except funct7[5] is honoured only for funct3=101 (SRAI). ADDI never decodes to SUB.
  - 0000011 LOAD: reg_write, alu_src, mem_read, mem_to_reg; alu_op=ADD; I-imm.
  - 0100011 STORE: alu_src, mem_write; alu_op=ADD; S-imm.
  - 1100011 BRANCH: branch; alu_op=SUB; B-imm. Comparison type is given by funct3 and resolved downstream.
  - 1101111 JAL: reg_write, jump; J-imm.
  - 1100111 JALR: reg_write, jump, jalr, alu_src; alu_op=ADD; I-imm.
  - 0110111 LUI: reg_write, alu_src; alu_op=PASS_B (10); U-imm.
  - 0010111 AUIPC: reg_write, alu_src, pc_to_alu; alu_op=ADD; U-imm.
  - Any other opcode: illegal=1 and all control signals 0 (NOP).
- Trap capture:
  - At the rising edge with reset_n=1, illegal=1 and trap_valid=0: trap_valid <= 1 and trap_pc <= current_procount.
  - Later illegal instructions do not overwrite trap_pc. Only reset clears it.
- instruction = 32'h0000_0000 is illegal (opcode 0000000).
- Unused funct fields on legal opcodes are not checked.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with wb_en=1, wb_rd=5, wb_data=32'hDEAD_BEEF -> all regs read 0, every control output 0, trap_valid=0.
- Write/read: write x5=32'h1234_5678. In the same cycle, instruction=32'h0050_0133 (add x2,x0,x5) -> rs2_data=0. Next cycle -> rs2_data=32'h1234_5678, reg_write=1, alu_op=0, rd=2.
- x0 protection: wb_en=1, wb_rd=0, wb_data=32'hFFFF_FFFF, then instruction=32'h0000_0093 (addi x1,x0,0) -> rs1_data=0, alu_src=1, imm=0.
- Immediates:
  - 32'hFE00_0EE3 (beq x0,x0,-4) -> imm=32'hFFFF_FFFC, branch=1, alu_op=1.
  - 32'h8000_006F (jal x0) -> imm=32'hFFF0_0000, jump=1.
  - 32'hABCD_E0B7 (lui x1) -> imm=32'hABCD_E000, alu_op=10.
- Trap:
  - pc=32'h0000_0010, instruction=32'hFFFF_FFFF -> illegal=1, controls 0; next edge trap_valid=1, trap_pc=32'h10.
  - Second illegal at pc=32'h20 -> trap_pc stays 32'h10.
  - Reset -> trap_valid=0, trap_pc=0.
- Shift/store: 32'h4030_D093 (srai x1,x1,3) -> alu_op=7. 32'h00A1_2223 (sw x10,4(x2)) -> mem_write=1, reg_write=0, imm=4.

Source files
------------

// File: rtl/decode_regfile.sv
// Decode stage of the single-cycle RV32I core: field split, immediate generation,
// control bundle, 32x32 register file and sticky illegal-instruction trap.
module decode_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_OP_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           instruction,
  input  logic [DATA_WIDTH-1:0] current_procount,
  input  logic                  wb_en,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [4:0]            rd,
  output logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  reg_write,
  output logic                  alu_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  branch,
  output logic                  jump,
  output logic                  jalr,
  output logic                  pc_to_alu,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  illegal,
  output logic                  trap_valid,
  output logic [DATA_WIDTH-1:0] trap_pc
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 4'd10;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;

  logic [DATA_WIDTH-1:0] regs_q [32];
  logic                  trap_valid_q, trap_valid_d;
  logic [DATA_WIDTH-1:0] trap_pc_q, trap_pc_d;

  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instruction[6:0];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign pc_out = current_procount;

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  function automatic logic [ALU_OP_W-1:0] alu_from_funct(input logic [2:0] f3, input logic alt);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Reads never see a same-cycle write, so the path stays loop-free.
  assign rs1_data = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : regs_q[rs2];

  always_comb begin
    imm        = '0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jalr       = 1'b0;
    pc_to_alu  = 1'b0;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        reg_write = 1'b1;
        alu_op    = alu_from_funct(funct3, instruction[30]);
      end
      OPC_OP_IMM: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm       = imm_i;
        alu_op    = alu_from_funct(funct3, instruction[30] && (funct3 == 3'b101));
      end
      OPC_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        imm        = imm_i;
      end
      OPC_STORE: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
        imm       = imm_s;
      end
      OPC_BRANCH: begin
        branch = 1'b1;
        alu_op = ALU_SUB;
        imm    = imm_b;
      end
      OPC_JAL: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        imm       = imm_j;
      end
      OPC_JALR: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        jalr      = 1'b1;
        alu_src   = 1'b1;
        imm       = imm_i;
      end
      OPC_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALU_PASS_B;
        imm       = imm_u;
      end
      OPC_AUIPC: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        pc_to_alu = 1'b1;
        imm       = imm_u;
      end
      default: illegal = 1'b1;
    endcase
    // Fields and immediate stay decoded under reset; only the control bundle is NOP'd.
    if (!reset_n) begin
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      jalr       = 1'b0;
      pc_to_alu  = 1'b0;
      alu_op     = ALU_ADD;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    trap_valid_d = trap_valid_q;
    trap_pc_d    = trap_pc_q;
    if (illegal && !trap_valid_q) begin
      trap_valid_d = 1'b1;
      trap_pc_d    = current_procount;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trap_valid_q <= 1'b0;
      trap_pc_q    <= '0;
    end else begin
      trap_valid_q <= trap_valid_d;
      trap_pc_q    <= trap_pc_d;
    end
  end

  assign trap_valid = trap_valid_q;
  assign trap_pc    = trap_pc_q;

endmodule

// File: tb/tb_decode_regfile.sv
// Scoreboard bench for decode_regfile: expectations queued with each stimulus
// and drained at the following falling edge.
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instruction, current_procount;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rs1_data, rs2_data, imm, pc_out, trap_pc;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg;
  logic        branch, jump, jalr, pc_to_alu, illegal, trap_valid;
  logic [3:0]  alu_op;

  decode_regfile #(.DATA_WIDTH(32), .ALU_OP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction),
    .current_procount(current_procount), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rd(rd), .funct3(funct3), .pc_out(pc_out), .reg_write(reg_write),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .jalr(jalr),
    .pc_to_alu(pc_to_alu), .alu_op(alu_op), .illegal(illegal),
    .trap_valid(trap_valid), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  localparam int S_RS1 = 0, S_RS2 = 1, S_IMM = 2, S_RD = 3, S_PC = 4, S_CTRL = 5,
                 S_ALU = 6, S_ILL = 7, S_TV = 8, S_TPC = 9;
  // Control bundle packed as {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jalr, pc_to_alu}
  localparam logic [31:0] RW = 32'h100, AS = 32'h080, MR = 32'h040, MW = 32'h020,
                          MTR = 32'h010, BR = 32'h008, JMP = 32'h004, JR = 32'h002, PTA = 32'h001;

  typedef struct {
    string       name;
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_regs [32];

  function automatic logic [31:0] sig(input int id);
    case (id)
      S_RS1:   return rs1_data;
      S_RS2:   return rs2_data;
      S_IMM:   return imm;
      S_RD:    return {27'b0, rd};
      S_PC:    return pc_out;
      S_CTRL:  return {23'b0, reg_write, alu_src, mem_read, mem_write, mem_to_reg,
                       branch, jump, jalr, pc_to_alu};
      S_ALU:   return {28'b0, alu_op};
      S_ILL:   return {31'b0, illegal};
      S_TV:    return {31'b0, trap_valid};
      default: return trap_pc;
    endcase
  endfunction

  task automatic expect_val(input string n, input int id, input logic [31:0] v);
    exp_t e;
    e.name = n; e.id = id; e.val = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    instruction = 32'hFFFF_FFFF; current_procount = 32'h0;
    step(); step();
    instruction = 32'h0050_0133;
    expect_val("rst_rs2_x5", S_RS2, 32'h0);
    expect_val("rst_ctrl", S_CTRL, 32'h0);
    expect_val("rst_aluop", S_ALU, 32'h0);
    expect_val("rst_rd_decoded", S_RD, 32'd2);
    expect_val("rst_tv", S_TV, 32'h0);
    expect_val("rst_tpc", S_TPC, 32'h0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    instruction = 32'hFFFF_FFFF;
    expect_val("rst_illegal_masked", S_ILL, 32'h0);
    expect_val("rst_ctrl_illegal", S_CTRL, 32'h0);
    expect_val("rst_rs1_x31", S_RS1, 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
    reset_n = 1'b1; wb_en = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
  endtask

  task automatic test_write_read();
    exp_t e;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
    instruction = 32'h0050_0133;
    expect_val("wr_same_cycle_old", S_RS2, 32'h0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
    model_regs[5] = 32'h1234_5678;
    wb_en = 1'b0;
    expect_val("wr_next_cycle", S_RS2, model_regs[5]);
    expect_val("wr_ctrl", S_CTRL, RW);
    expect_val("wr_aluop", S_ALU, 32'd0);
    expect_val("wr_rd", S_RD, 32'd2);
    expect_val("wr_imm_r", S_IMM, 32'h0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
  endtask

  task automatic test_x0();
    exp_t e;
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    step();
    wb_en = 1'b0;
    instruction = 32'h0000_0093;
    expect_val("x0_rs1", S_RS1, 32'h0);
    expect_val("x0_ctrl", S_CTRL, RW | AS);
    expect_val("x0_imm", S_IMM, 32'h0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
  endtask

  task automatic test_immediates();
    exp_t        e;
    logic [31:0] ins [8];
    logic [31:0] eimm [8];
    logic [31:0] ectl [8];
    logic [31:0] ealu [8];
    ins[0] = 32'hFE00_0EE3; eimm[0] = 32'hFFFF_FFFC; ectl[0] = BR;       ealu[0] = 1;
    ins[1] = 32'h8000_006F; eimm[1] = 32'hFFF0_0000; ectl[1] = RW | JMP; ealu[1] = 0;
    ins[2] = 32'hABCD_E0B7; eimm[2] = 32'hABCD_E000; ectl[2] = RW | AS;  ealu[2] = 10;
    ins[3] = 32'hFFC1_2083; eimm[3] = 32'hFFFF_FFFC; ectl[3] = RW | AS | MR | MTR; ealu[3] = 0;
    ins[4] = 32'hFE11_2E23; eimm[4] = 32'hFFFF_FFFC; ectl[4] = AS | MW;  ealu[4] = 0;
    ins[5] = 32'h0000_8067; eimm[5] = 32'h0;         ectl[5] = RW | JMP | JR | AS; ealu[5] = 0;
    ins[6] = 32'h1234_5097; eimm[6] = 32'h1234_5000; ectl[6] = RW | AS | PTA; ealu[6] = 0;
    ins[7] = 32'h4000_0013; eimm[7] = 32'h0000_0400; ectl[7] = RW | AS;  ealu[7] = 0;
    for (int i = 0; i < 8; i++) begin
      instruction = ins[i];
      current_procount = 32'h100 + 4 * i;
      expect_val($sformatf("imm_%0d", i), S_IMM, eimm[i]);
      expect_val($sformatf("ctrl_%0d", i), S_CTRL, ectl[i]);
      expect_val($sformatf("alu_%0d", i), S_ALU, ealu[i]);
      expect_val($sformatf("pc_%0d", i), S_PC, 32'h100 + 4 * i);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); vectors++;
        if (sig(e.id) !== e.val) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
        end
      end
      step();
    end
  endtask

  task automatic test_alu_ops();
    exp_t        e;
    logic [31:0] ins [6];
    logic [31:0] ealu [6];
    ins[0] = 32'h4030_D093; ealu[0] = 7;
    ins[1] = 32'h0030_D093; ealu[1] = 6;
    ins[2] = 32'h4000_0033; ealu[2] = 1;
    ins[3] = 32'h0000_3033; ealu[3] = 4;
    ins[4] = 32'h0000_7033; ealu[4] = 9;
    ins[5] = 32'h0000_6013; ealu[5] = 8;
    for (int i = 0; i < 6; i++) begin
      instruction = ins[i];
      expect_val($sformatf("aluop_%0d", i), S_ALU, ealu[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); vectors++;
        if (sig(e.id) !== e.val) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
        end
      end
      step();
    end
    instruction = 32'h00A1_2223;
    expect_val("sw_ctrl", S_CTRL, AS | MW);
    expect_val("sw_imm", S_IMM, 32'd4);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int r = 1; r <= 4; r++) begin
      wb_en = 1'b1; wb_rd = r[4:0]; wb_data = $urandom;
      model_regs[r] = wb_data;
      step();
    end
    wb_en = 1'b0;
    instruction = 32'h0020_8033;
    expect_val("b2b_rs1_x1", S_RS1, model_regs[1]);
    expect_val("b2b_rs2_x2", S_RS2, model_regs[2]);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    instruction = 32'h0041_8033;
    expect_val("b2b_rs1_x3", S_RS1, model_regs[3]);
    expect_val("b2b_rs2_x4", S_RS2, model_regs[4]);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
  endtask

  task automatic test_trap();
    exp_t e;
    current_procount = 32'h10; instruction = 32'hFFFF_FFFF;
    expect_val("trap_illegal", S_ILL, 32'h1);
    expect_val("trap_ctrl_nop", S_CTRL, 32'h0);
    expect_val("trap_alu_nop", S_ALU, 32'h0);
    expect_val("trap_imm_zero", S_IMM, 32'h0);
    expect_val("trap_tv_before", S_TV, 32'h0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
    current_procount = 32'h20; instruction = 32'h0000_0000;
    expect_val("trap_tv_set", S_TV, 32'h1);
    expect_val("trap_pc_first", S_TPC, 32'h10);
    expect_val("trap_zero_illegal", S_ILL, 32'h1);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
    instruction = 32'h0050_0133;
    expect_val("trap_pc_sticky", S_TPC, 32'h10);
    expect_val("trap_tv_sticky", S_TV, 32'h1);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
    reset_n = 1'b0; wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'hCAFE_F00D;
    step();
    reset_n = 1'b1; wb_en = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    instruction = 32'h0060_0133;
    expect_val("rst2_tv", S_TV, 32'h0);
    expect_val("rst2_tpc", S_TPC, 32'h0);
    expect_val("rst2_x6_ignored", S_RS2, model_regs[6]);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    instruction = 32'h0050_0133;
    expect_val("rst2_x5_cleared", S_RS2, model_regs[5]);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); vectors++;
      if (sig(e.id) !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, sig(e.id), e.val);
      end
    end
    step();
  endtask

  initial begin
    reset_n = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    instruction = 32'h0; current_procount = 32'h0;
    test_reset();
    test_write_read();
    test_x0();
    test_immediates();
    test_alu_ops();
    test_back_to_back();
    test_trap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
